// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine host driver.
//   - state_e      : transaction FSM states
//   - CH_*         : special characters understood by the match engine
//   - *_DEF        : default buffer depths and result timeout
package sme_pkg;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int TIMEOUT_DEF = 255;

  // Pattern metacharacters interpreted by the engine, not by this driver.
  localparam logic [7:0] CH_CARET  = 8'h5E;  // '^'
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CH_DOT    = 8'h2E;  // '.'
  localparam logic [7:0] CH_STAR   = 8'h2A;  // '*'
  localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_STR = 2'd1,
    ST_SEND_PAT = 2'd2,
    ST_WAIT     = 2'd3
  } state_e;

endpackage

// File: rtl/sme_char_buf.sv
// Character buffer: DEPTH x 8-bit registers filled in order, with a length
// counter and a sticky overflow flag.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears length/overflow)
//   clr             zero the length and the overflow flag (wins over wr_en)
//   wr_en, wr_data  append one character at index len
//   rd_addr/rd_data asynchronous read port
//   len             number of characters stored
//   overflow        set when a write arrives while the buffer is full
module sme_char_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len,
  output logic          overflow
);

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] len_q;
  logic          ovf_q;
  logic          full;
  logic          store;

  assign full  = (len_q == LW'(DEPTH));
  assign store = wr_en && !clr && !full;

  // NOTE: non-blocking assignments for every register so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (wr_en) begin
      if (full) ovf_q <= 1'b1;
      else      len_q <= len_q + LW'(1);
    end
  end

  // NOTE: the character storage has no reset; only the length decides what
  // is valid, so stale contents are never observed and need no clearing.
  always_ff @(posedge clk) begin
    if (store) mem_q[len_q[AW-1:0]] <= wr_data;
  end

  assign rd_data  = mem_q[rd_addr];
  assign len      = len_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/sme_host_driver.sv
// Host-side transmitter for the string-match engine.
// The host fills a string buffer and a pattern buffer, then pulses start.
// The driver streams the string (isstring) and/or the pattern (ispattern)
// back-to-back, waits for the engine's valid (or a timeout) and returns
// the result on a one-cycle res_valid strobe.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   wr_en, wr_sel, wr_data, clr      buffer load / clear (honoured in IDLE only)
//   start, new_string                begin string+pattern or pattern-only send
//   chardata, isstring, ispattern    registered character interface to engine
//   valid, match, match_index        engine result
//   busy                             transaction in progress
//   res_valid/match/index/timeout    captured result
//   err                              start rejected (one-cycle pulse)
//   overflow                         sticky: a buffer write was dropped
module sme_host_driver
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       clr,
  input  logic       start,
  input  logic       new_string,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       busy,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       err,
  output logic       overflow
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [SLW-1:0] s_idx_q, s_idx_d;
  logic [PLW-1:0] p_idx_q, p_idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           isstring_q, isstring_d;
  logic           ispattern_q, ispattern_d;
  logic           string_sent_q, string_sent_d;
  logic           res_valid_q, res_valid_d;
  logic           res_match_q, res_match_d;
  logic [4:0]     res_index_q, res_index_d;
  logic           res_timeout_q, res_timeout_d;
  logic           err_q, err_d;

  logic           idle;
  logic           buf_clr, str_wr, pat_wr;
  logic [7:0]     str_rd, pat_rd;
  logic [SLW-1:0] str_len;
  logic [PLW-1:0] pat_len;
  logic           str_ovf, pat_ovf;
  logic           start_go, start_ok;
  logic           str_done, pat_done, tmo_hit;

  // Host access to the buffers is frozen while a transaction runs so the
  // characters being streamed cannot change under the engine.
  assign idle    = (state_q == ST_IDLE);
  assign buf_clr = idle && clr;
  assign str_wr  = idle && wr_en && !clr && !wr_sel;
  assign pat_wr  = idle && wr_en && !clr &&  wr_sel;

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .wr_en    (str_wr),
    .wr_data  (wr_data),
    .rd_addr  (s_idx_q[SAW-1:0]),
    .rd_data  (str_rd),
    .len      (str_len),
    .overflow (str_ovf)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .wr_en    (pat_wr),
    .wr_data  (wr_data),
    .rd_addr  (p_idx_q[PAW-1:0]),
    .rd_data  (pat_rd),
    .len      (pat_len),
    .overflow (pat_ovf)
  );

  // A pattern-only send is meaningful only once the engine holds a string.
  assign start_go = idle && start;
  assign start_ok = (pat_len != '0) &&
                    (new_string ? (str_len != '0) : string_sent_q);

  // Indices count characters already placed on the interface, so "done"
  // means the last character is on the wire this cycle.
  assign str_done = (s_idx_q == str_len);
  assign pat_done = (p_idx_q == pat_len);
  assign tmo_hit  = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start_go && start_ok)
                     state_d = new_string ? ST_SEND_STR : ST_SEND_PAT;
      ST_SEND_STR: if (str_done) state_d = ST_SEND_PAT;
      ST_SEND_PAT: if (pat_done) state_d = ST_WAIT;
      ST_WAIT:     if (valid || tmo_hit) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. The engine-side outputs are computed for
  // the cycle being entered, which is what puts the first character on the
  // wire the cycle after start and keeps string and pattern contiguous.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    s_idx_d       = s_idx_q;
    p_idx_d       = p_idx_q;
    cnt_d         = cnt_q;
    chardata_d    = 8'h00;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    string_sent_d = string_sent_q;
    res_valid_d   = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    err_d         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr) string_sent_d = 1'b0;
        if (start_go) begin
          if (!start_ok) begin
            err_d = 1'b1;
          end else if (new_string) begin
            isstring_d = 1'b1;
            chardata_d = str_rd;
            s_idx_d    = SLW'(1);
          end else begin
            ispattern_d = 1'b1;
            chardata_d  = pat_rd;
            p_idx_d     = PLW'(1);
          end
        end
      end

      ST_SEND_STR: begin
        if (str_done) begin
          s_idx_d       = '0;
          string_sent_d = 1'b1;
          ispattern_d   = 1'b1;
          chardata_d    = pat_rd;
          p_idx_d       = PLW'(1);
        end else begin
          isstring_d = 1'b1;
          chardata_d = str_rd;
          s_idx_d    = s_idx_q + SLW'(1);
        end
      end

      ST_SEND_PAT: begin
        if (pat_done) begin
          p_idx_d = '0;
          cnt_d   = '0;
        end else begin
          ispattern_d = 1'b1;
          chardata_d  = pat_rd;
          p_idx_d     = p_idx_q + PLW'(1);
        end
      end

      ST_WAIT: begin
        // A real result on the expiry cycle still takes precedence.
        if (valid) begin
          res_valid_d   = 1'b1;
          res_match_d   = match;
          res_index_d   = match_index;
          res_timeout_d = 1'b0;
        end else if (tmo_hit) begin
          res_valid_d   = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s_idx_q       <= '0;
      p_idx_q       <= '0;
      cnt_q         <= '0;
      chardata_q    <= 8'h00;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      string_sent_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      s_idx_q       <= s_idx_d;
      p_idx_q       <= p_idx_d;
      cnt_q         <= cnt_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      string_sent_q <= string_sent_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      err_q         <= err_d;
    end
  end

  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign busy        = !idle;
  assign res_valid   = res_valid_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;
  assign err         = err_q;
  assign overflow    = str_ovf || pat_ovf;

endmodule

// File: tb/tb_sme_host_driver.sv
// Scoreboard bench for sme_host_driver. The driver keeps a reference model
// (character queues, overflow and string-sent flags) and pushes the events
// the engine interface must show, each stamped with its expected cycle.
// A monitor on the falling edge pops and compares every observed event.
module tb_sme_host_driver;
  import sme_pkg::*;

  localparam int          TB_TMO = 10;
  localparam int unsigned STR_N  = 32;
  localparam int unsigned PAT_N  = 8;

  localparam logic [3:0] K_STR = 4'b1000;
  localparam logic [3:0] K_PAT = 4'b0100;
  localparam logic [3:0] K_RES = 4'b0010;
  localparam logic [3:0] K_ERR = 4'b0001;

  logic       clk = 1'b0;
  logic       reset, wr_en, wr_sel, clr, start, new_string;
  logic [7:0] wr_data;
  logic       valid, match;
  logic [4:0] match_index;
  logic [7:0] chardata;
  logic       isstring, ispattern, busy, res_valid, res_match, res_timeout, err, overflow;
  logic [4:0] res_index;

  sme_host_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TB_TMO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .clr(clr), .start(start), .new_string(new_string), .chardata(chardata),
    .isstring(isstring), .ispattern(ispattern), .valid(valid), .match(match),
    .match_index(match_index), .busy(busy), .res_valid(res_valid),
    .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout),
    .err(err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0]  kind;
    int unsigned at;
    logic [15:0] pay;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state
  logic [7:0] str_m[$];
  logic [7:0] pat_m[$];
  bit         ovf_m, sent_m;
  bit         held_m, held_t;
  logic [4:0] held_i;

  initial begin
    held_m = 1'b0; held_t = 1'b0; held_i = 5'd0;
  end

  // Monitor
  always @(negedge clk) begin : mon
    ev_t         e;
    logic [3:0]  k;
    logic [15:0] pay;
    k = {isstring, ispattern, res_valid, err};
    if (k != 4'd0) begin
      if (res_valid)      pay = {9'd0, res_timeout, res_match, res_index};
      else if (err)       pay = 16'd0;
      else                pay = {8'd0, chardata};
      if (exp_q.size() == 0) begin
        check("unexpected_event", 64'(k), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("event", {12'd0, k, cyc, pay}, {12'd0, e.kind, e.at, e.pay});
        if (e.kind == K_RES) begin
          held_t = e.pay[6];
          held_m = e.pay[5];
          held_i = e.pay[4:0];
        end
      end
    end else begin
      check("chardata_quiet", 64'(chardata), 64'd0);
    end
    if (!res_valid)
      check("res_hold", 64'({res_timeout, res_match, res_index}), 64'({held_t, held_m, held_i}));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick;
    wr_en = 1'b0;
    if (!sel) begin
      if (str_m.size() < STR_N) str_m.push_back(d); else ovf_m = 1'b1;
    end else begin
      if (pat_m.size() < PAT_N) pat_m.push_back(d); else ovf_m = 1'b1;
    end
  endtask

  task automatic wr_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
  endtask

  task automatic do_clr(input bit with_wr);
    clr = 1'b1; wr_en = with_wr; wr_sel = 1'b0; wr_data = 8'h41;
    tick;
    clr = 1'b0; wr_en = 1'b0;
    str_m.delete(); pat_m.delete();
    ovf_m = 1'b0; sent_m = 1'b0;
    check("overflow_after_clr", 64'(overflow), 64'(ovf_m));
  endtask

  // One start attempt. delay < TB_TMO: engine answers delay cycles after
  // WAIT entry; otherwise the result must be a timeout and the late valid
  // is ignored.
  task automatic run_txn(input bit ns, input int unsigned delay, input bit junk,
                         input bit m, input logic [4:0] idx);
    int unsigned n, ls, lp, w0, res_at, last;
    bit ok;
    n  = cyc;
    ok = (pat_m.size() > 0) && (ns ? (str_m.size() > 0) : sent_m);
    start = 1'b1; new_string = ns;
    if (!ok) begin
      exp_q.push_back('{K_ERR, n + 1, 16'd0});
      tick;
      start = 1'b0; new_string = 1'b0;
      check("busy_after_reject", 64'(busy), 64'd0);
      tick;
      return;
    end
    ls = ns ? str_m.size() : 0;
    lp = pat_m.size();
    for (int unsigned i = 0; i < ls; i++) exp_q.push_back('{K_STR, n + 1 + i, {8'd0, str_m[i]}});
    for (int unsigned i = 0; i < lp; i++) exp_q.push_back('{K_PAT, n + 1 + ls + i, {8'd0, pat_m[i]}});
    w0 = n + ls + lp + 1;
    if (delay < TB_TMO) begin
      res_at = w0 + delay + 1;
      exp_q.push_back('{K_RES, res_at, {9'd0, 1'b0, m, idx}});
    end else begin
      res_at = w0 + TB_TMO;
      exp_q.push_back('{K_RES, res_at, {9'd0, 1'b1, 1'b0, 5'd0}});
    end
    if (ns) sent_m = 1'b1;
    last = (w0 + delay > res_at) ? w0 + delay : res_at;
    tick;
    start = 1'b0; new_string = 1'b0;
    while (cyc <= last) begin
      check("busy", 64'(busy), 64'(cyc < res_at));
      wr_en = 1'b0; start = 1'b0; valid = 1'b0; match = 1'b0; match_index = 5'd0;
      if (cyc == w0 + delay) begin
        valid = 1'b1; match = m; match_index = idx;
      end else if (junk && cyc < w0) begin
        wr_en = 1'($urandom_range(0, 1)); wr_sel = 1'($urandom_range(0, 1));
        wr_data = 8'($urandom_range(32, 126));
        start = 1'($urandom_range(0, 1)); new_string = 1'($urandom_range(0, 1));
        valid = 1'($urandom_range(0, 1)); match = 1'($urandom_range(0, 1));
        match_index = 5'($urandom_range(0, 31));
      end
      tick;
    end
    wr_en = 1'b0; start = 1'b0; new_string = 1'b0;
    valid = 1'b0; match = 1'b0; match_index = 5'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, exp_q=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin : drv
    int unsigned n;
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 8'd0; clr = 1'b0;
    start = 1'b0; new_string = 1'b0; valid = 1'b0; match = 1'b0; match_index = 5'd0;
    str_m.delete(); pat_m.delete(); ovf_m = 1'b0; sent_m = 1'b0;
    tick; tick; tick;
    reset = 1'b0;
    tick;

    // Reset state
    check("rst_isstring",  64'(isstring),  64'd0);
    check("rst_ispattern", 64'(ispattern), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_results",   64'({res_valid, res_match, res_index, res_timeout}), 64'd0);
    check("rst_err_ovf",   64'({err, overflow}), 64'd0);

    // Empty pattern, then pattern-only with no string sent: both rejected
    run_txn(1'b0, 0, 1'b0, 1'b0, 5'd0);
    wr_str(1'b0, "hello world");
    wr_str(1'b1, "wor");
    run_txn(1'b0, 0, 1'b0, 1'b0, 5'd0);

    // Full string+pattern send, then pattern-only reuse
    run_txn(1'b1, 3, 1'b0, 1'b1, 5'd6);
    run_txn(1'b0, 0, 1'b1, 1'b0, 5'd17);

    // Anchored pattern; valid on the expiry cycle; timeout with a late valid
    do_clr(1'b1);
    wr_str(1'b0, "hello world");
    wr(1'b1, CH_CARET);
    wr_str(1'b1, "he");
    run_txn(1'b1, TB_TMO - 1, 1'b0, 1'b1, 5'd0);
    run_txn(1'b0, 20, 1'b0, 1'b1, 5'd9);

    // Empty string with new_string = 1
    do_clr(1'b0);
    wr(1'b1, CH_DOT);
    run_txn(1'b1, 0, 1'b0, 1'b0, 5'd0);

    // String overflow: 33rd write dropped, only 32 chars sent
    do_clr(1'b0);
    for (int i = 0; i < 32; i++) wr(1'b0, 8'($urandom_range(97, 122)));
    check("ovf_at_32", 64'(overflow), 64'(ovf_m));
    wr(1'b0, CH_SPACE);
    check("ovf_at_33", 64'(overflow), 64'(ovf_m));
    wr(1'b1, CH_STAR);
    wr(1'b1, CH_DOLLAR);
    run_txn(1'b1, 2, 1'b1, 1'b1, 5'd31);
    do_clr(1'b0);

    // Pattern overflow
    for (int i = 0; i < 9; i++) wr(1'b1, 8'($urandom_range(97, 122)));
    check("pat_ovf", 64'(overflow), 64'(ovf_m));
    do_clr(1'b0);

    // Reset on the 5th isstring cycle
    wr_str(1'b0, "abcdefgh");
    wr_str(1'b1, "cd");
    n = cyc;
    start = 1'b1; new_string = 1'b1;
    for (int unsigned i = 0; i < 5; i++) exp_q.push_back('{K_STR, n + 1 + i, {8'd0, str_m[i]}});
    tick;
    start = 1'b0; new_string = 1'b0;
    while (cyc < n + 5) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    str_m.delete(); pat_m.delete(); ovf_m = 1'b0; sent_m = 1'b0;
    held_m = 1'b0; held_t = 1'b0; held_i = 5'd0;
    check("abort_framing", 64'({isstring, ispattern}), 64'd0);
    check("abort_busy",    64'(busy), 64'd0);
    check("abort_results", 64'({res_valid, res_match, res_index, res_timeout, err}), 64'd0);
    wr_str(1'b1, "ab");
    run_txn(1'b0, 0, 1'b0, 1'b0, 5'd0);

    // Randomised transactions
    for (int it = 0; it < 30; it++) begin
      int unsigned nsw, npw;
      if ($urandom_range(0, 3) == 0) do_clr(1'($urandom_range(0, 1)));
      nsw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 34) : $urandom_range(0, 3);
      npw = $urandom_range(0, 2);
      for (int unsigned i = 0; i < nsw; i++) wr(1'b0, 8'($urandom_range(32, 126)));
      for (int unsigned i = 0; i < npw; i++) wr(1'b1, 8'($urandom_range(32, 126)));
      check("rand_ovf", 64'(overflow), 64'(ovf_m));
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    tick; tick;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
